// File: rtl/stack_arb_pkg.sv
// Shared definitions for the two-requester stack sequencer: stack command codes,
// controller states and default geometry.
package stack_arb_pkg;

  localparam int DEPTH_DEF = 5;
  localparam int DW_DEF    = 4;
  localparam int IW_DEF    = 3;

  localparam logic [1:0] CMD_NOP  = 2'b00;
  localparam logic [1:0] CMD_PUSH = 2'b01;
  localparam logic [1:0] CMD_POP  = 2'b10;
  localparam logic [1:0] CMD_GET  = 2'b11;

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    IDLE  = 2'd1,
    ISSUE = 2'd2,
    RESP  = 2'd3
  } state_e;

endpackage

// File: rtl/stack_arbiter_rr.sv
// Two-way round-robin picker: combinational winner, pointer moves to the loser on grant.
// Zero latency select; requesters simply hold REQ until granted.
module rr_arbiter_2 (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic req0_i,
  input  logic req1_i,
  input  logic grant_en_i,
  output logic win_o,
  output logic any_o
);

  logic ptr_q, ptr_d;

  // ptr_q names the requester that wins a tie
  assign win_o = (req0_i && req1_i) ? ptr_q : req1_i;
  assign any_o = req0_i || req1_i;
  assign ptr_d = (grant_en_i && any_o) ? ~win_o : ptr_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/stack_arbiter.sv
// Shares one external stack between two requesters; legal op = accept, ISSUE, RESP (3 cycles),
// rejected op or nop = accept, RESP (2 cycles). Requesters hold REQ until their GNT pulse.
module stack_arbiter
  import stack_arb_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int DW    = DW_DEF,
  parameter int IW    = IW_DEF
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          req0_i,
  input  logic          req1_i,
  input  logic [1:0]    cmd0_i,
  input  logic [1:0]    cmd1_i,
  input  logic [IW-1:0] idx0_i,
  input  logic [IW-1:0] idx1_i,
  input  logic [DW-1:0] wdata0_i,
  input  logic [DW-1:0] wdata1_i,
  output logic          gnt0_o,
  output logic          gnt1_o,
  output logic          done0_o,
  output logic          done1_o,
  output logic          err0_o,
  output logic          err1_o,
  output logic [DW-1:0] rdata0_o,
  output logic [DW-1:0] rdata1_o,
  output logic [1:0]    stk_command_o,
  output logic [IW-1:0] stk_index_o,
  output logic          stk_reset_o,
  inout  wire  [DW-1:0] stk_io_io,
  output logic [2:0]    count_o,
  output logic          full_o,
  output logic          empty_o
);

  localparam logic [2:0] DEPTH_C = 3'(DEPTH);

  state_e        state_q;
  logic          stk_reset_q;
  logic          gnt0_q, gnt1_q, done0_q, done1_q, err0_q, err1_q;
  logic [DW-1:0] rdata0_q, rdata1_q;
  logic [1:0]    cmd_q;
  logic [IW-1:0] idx_q;
  logic [DW-1:0] wdata_q;
  logic          drive_q;
  logic          win_q;
  logic [2:0]    count_q, count_d;
  logic          full_q, empty_q;

  logic          win, any_req, accept, illegal;
  logic [1:0]    cmd_w;
  logic [IW-1:0] idx_w;
  logic [DW-1:0] wdata_w;

  assign accept = (state_q == IDLE) && any_req;

  rr_arbiter_2 u_rr (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .req0_i     (req0_i),
    .req1_i     (req1_i),
    .grant_en_i (accept),
    .win_o      (win),
    .any_o      (any_req)
  );

  assign cmd_w   = win ? cmd1_i   : cmd0_i;
  assign idx_w   = win ? idx1_i   : idx0_i;
  assign wdata_w = win ? wdata1_i : wdata0_i;

  assign illegal = ((cmd_w == CMD_PUSH) && full_q)
                || ((cmd_w == CMD_POP)  && empty_q)
                || ((cmd_w == CMD_GET)  && (int'(idx_w) >= int'(count_q)));

  // Range guards are redundant with the legality check but keep COUNT bounded regardless
  always_comb begin
    count_d = count_q;
    if (state_q == ISSUE) begin
      if ((cmd_q == CMD_PUSH) && (count_q != DEPTH_C)) begin
        count_d = count_q + 3'd1;
      end else if ((cmd_q == CMD_POP) && (count_q != 3'd0)) begin
        count_d = count_q - 3'd1;
      end
    end
  end

  assign stk_io_io = drive_q ? wdata_q : {DW{1'bz}};

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= INIT;
      stk_reset_q <= 1'b1;
      gnt0_q      <= 1'b0;
      gnt1_q      <= 1'b0;
      done0_q     <= 1'b0;
      done1_q     <= 1'b0;
      err0_q      <= 1'b0;
      err1_q      <= 1'b0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
      cmd_q       <= CMD_NOP;
      idx_q       <= '0;
      wdata_q     <= '0;
      drive_q     <= 1'b0;
      win_q       <= 1'b0;
      count_q     <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
    end else begin
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      err0_q  <= 1'b0;
      err1_q  <= 1'b0;
      count_q <= count_d;
      full_q  <= (count_d == DEPTH_C);
      empty_q <= (count_d == 3'd0);
      case (state_q)
        INIT: begin
          stk_reset_q <= 1'b0;
          state_q     <= IDLE;
        end
        IDLE: begin
          if (any_req) begin
            win_q  <= win;
            gnt0_q <= ~win;
            gnt1_q <= win;
            if (illegal || (cmd_w == CMD_NOP)) begin
              // No stack cycle: GNT and DONE share the RESP cycle
              done0_q <= ~win;
              done1_q <= win;
              err0_q  <= ~win & illegal;
              err1_q  <= win & illegal;
              state_q <= RESP;
            end else begin
              cmd_q   <= cmd_w;
              idx_q   <= idx_w;
              wdata_q <= wdata_w;
              drive_q <= (cmd_w == CMD_PUSH);
              state_q <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if ((cmd_q == CMD_POP) || (cmd_q == CMD_GET)) begin
            if (win_q) rdata1_q <= stk_io_io;
            else       rdata0_q <= stk_io_io;
          end
          cmd_q   <= CMD_NOP;
          idx_q   <= '0;
          drive_q <= 1'b0;
          done0_q <= ~win_q;
          done1_q <= win_q;
          state_q <= RESP;
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= INIT;
        end
      endcase
    end
  end

  assign gnt0_o        = gnt0_q;
  assign gnt1_o        = gnt1_q;
  assign done0_o       = done0_q;
  assign done1_o       = done1_q;
  assign err0_o        = err0_q;
  assign err1_o        = err1_q;
  assign rdata0_o      = rdata0_q;
  assign rdata1_o      = rdata1_q;
  assign stk_command_o = cmd_q;
  assign stk_index_o   = idx_q;
  assign stk_reset_o   = stk_reset_q;
  assign count_o       = count_q;
  assign full_o        = full_q;
  assign empty_o       = empty_q;

endmodule

// File: tb/tb_stack_arbiter.sv
// Scoreboard bench for stack_arbiter with a behavioural 5-entry stack on the shared bus.
module tb_stack_arbiter;

  localparam logic [1:0] NOP = 2'b00, PUSH = 2'b01, POP = 2'b10, GET = 2'b11;

  logic       clk, rst_n;
  logic       req0, req1;
  logic [1:0] cmd0, cmd1;
  logic [2:0] idx0, idx1;
  logic [3:0] wd0, wd1;
  logic       gnt0, gnt1, done0, done1, err0, err1;
  logic [3:0] rdata0, rdata1;
  logic [1:0] stk_command;
  logic [2:0] stk_index;
  logic       stk_reset;
  wire  [3:0] stk_io;
  logic [2:0] count;
  logic       full, empty;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int         w;
    logic       err;
    logic [3:0] rd;
    logic [2:0] cnt;
  } exp_t;
  exp_t sbq[$];

  stack_arbiter dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .req0_i(req0), .req1_i(req1),
    .cmd0_i(cmd0), .cmd1_i(cmd1),
    .idx0_i(idx0), .idx1_i(idx1),
    .wdata0_i(wd0), .wdata1_i(wd1),
    .gnt0_o(gnt0), .gnt1_o(gnt1),
    .done0_o(done0), .done1_o(done1),
    .err0_o(err0), .err1_o(err1),
    .rdata0_o(rdata0), .rdata1_o(rdata1),
    .stk_command_o(stk_command), .stk_index_o(stk_index),
    .stk_reset_o(stk_reset), .stk_io_io(stk_io),
    .count_o(count), .full_o(full), .empty_o(empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural stack: drives the bus combinationally for pop/get, stores on push
  logic [3:0] mem [0:7];
  logic [2:0] sp;
  logic       drv_en;
  logic [3:0] drv_val;
  int         slot;

  always @(posedge clk) begin
    if (stk_reset) sp <= 3'd0;
    else if (stk_command == PUSH && sp < 3'd5) begin
      mem[sp] <= stk_io;
      sp      <= sp + 3'd1;
    end else if (stk_command == POP && sp != 3'd0) sp <= sp - 3'd1;
  end

  always_comb begin
    drv_en  = 1'b0;
    drv_val = 4'h0;
    slot    = -1;
    if (stk_command == POP) slot = int'(sp) - 1;
    else if (stk_command == GET) slot = int'(sp) - 1 - int'(stk_index);
    if (slot >= 0) begin
      drv_en  = 1'b1;
      drv_val = mem[slot[2:0]];
    end
  end

  assign stk_io = drv_en ? drv_val : 4'bzzzz;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out (t=%0t)", name, $time);
  endtask

  // Monitor: every DONE pulse retires the oldest expectation
  always @(negedge clk) begin : monitor
    int   w;
    exp_t e;
    if (rst_n && (done0 || done1)) begin
      if (done0 && done1) timeout("done_both_high");
      w = done1 ? 1 : 0;
      if (sbq.size() == 0) begin
        timeout("unexpected_done");
      end else begin
        e = sbq.pop_front();
        check("done_requester", 8'(w), 8'(e.w));
        check("done_err", {7'd0, w ? err1 : err0}, {7'd0, e.err});
        check("done_rdata", {4'd0, w ? rdata1 : rdata0}, {4'd0, e.rd});
        check("done_count", {5'd0, count}, {5'd0, e.cnt});
      end
    end
  end

  task automatic set_req(input int w, input logic r, input logic [1:0] c,
                         input logic [2:0] ix, input logic [3:0] wd);
    if (w == 0) begin req0 = r; cmd0 = c; idx0 = ix; wd0 = wd; end
    else        begin req1 = r; cmd1 = c; idx1 = ix; wd1 = wd; end
  endtask

  task automatic op(input int w, input logic [1:0] c, input logic [2:0] ix,
                    input logic [3:0] wd, input logic e, input logic [3:0] rd,
                    input logic [2:0] cnt, input bit use_sb);
    bit   got;
    logic quick;
    exp_t x;
    quick = e || (c == NOP);
    if (use_sb) begin
      x.w = w; x.err = e; x.rd = rd; x.cnt = cnt;
      sbq.push_back(x);
    end
    set_req(w, 1'b1, c, ix, wd);
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if ((w == 0) ? gnt0 : gnt1) got = 1;
    end
    if (!got) begin
      timeout("gnt_wait");
      set_req(w, 1'b0, NOP, 3'd0, 4'd0);
      return;
    end
    check("gnt_cycle_command", {6'd0, stk_command}, {6'd0, quick ? NOP : c});
    check("gnt_cycle_done", {7'd0, (w == 0) ? done0 : done1}, {7'd0, quick});
    if (!quick && c == PUSH) check("issue_bus_data", {4'd0, stk_io}, {4'd0, wd});
    if (!quick && c == GET) check("issue_index", {5'd0, stk_index}, {5'd0, ix});
    set_req(w, 1'b0, NOP, 3'd0, 4'd0);
    if (!quick) begin
      got = 0;
      for (int i = 0; i < 5 && !got; i++) begin
        @(negedge clk);
        if ((w == 0) ? done0 : done1) got = 1;
      end
      if (!got) timeout("done_wait");
    end
  endtask

  task automatic sb_push(input int w, input logic e, input logic [3:0] rd, input logic [2:0] cnt);
    exp_t x;
    x.w = w; x.err = e; x.rd = rd; x.cnt = cnt;
    sbq.push_back(x);
  endtask

  initial begin : main
    bit got;
    logic [3:0] pv [5];
    rst_n = 1'b0;
    set_req(0, 1'b1, PUSH, 3'd0, 4'h7);
    set_req(1, 1'b0, NOP, 3'd0, 4'h0);
    repeat (3) @(negedge clk);
    check("rst_gnt0", {7'd0, gnt0}, 8'd0);
    check("rst_done0", {7'd0, done0}, 8'd0);
    check("rst_err0", {7'd0, err0}, 8'd0);
    check("rst_rdata0", {4'd0, rdata0}, 8'd0);
    check("rst_rdata1", {4'd0, rdata1}, 8'd0);
    check("rst_command", {6'd0, stk_command}, 8'd0);
    check("rst_index", {5'd0, stk_index}, 8'd0);
    check("rst_count", {5'd0, count}, 8'd0);
    check("rst_empty", {7'd0, empty}, 8'd1);
    check("rst_full", {7'd0, full}, 8'd0);
    check("rst_stk_reset", {7'd0, stk_reset}, 8'd1);

    rst_n = 1'b1;
    #1 check("init_stk_reset", {7'd0, stk_reset}, 8'd1);
    @(negedge clk);
    check("init_no_gnt", {7'd0, gnt0}, 8'd0);
    check("init_stk_reset_drop", {7'd0, stk_reset}, 8'd0);
    op(0, PUSH, 3'd0, 4'h7, 1'b0, 4'h0, 3'd1, 1);

    op(0, POP, 3'd0, 4'h0, 1'b0, 4'h7, 3'd0, 1);
    pv = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5};
    for (int i = 0; i < 5; i++) op(0, PUSH, 3'd0, pv[i], 1'b0, 4'h7, 3'(i + 1), 1);
    op(0, PUSH, 3'd0, 4'h9, 1'b1, 4'h7, 3'd5, 1);
    check("full_after_reject", {7'd0, full}, 8'd1);
    check("count_after_reject", {5'd0, count}, 8'd5);

    for (int i = 0; i < 5; i++) op(1, POP, 3'd0, 4'h0, 1'b0, pv[4 - i], 3'(4 - i), 1);
    check("empty_after_drain", {7'd0, empty}, 8'd1);

    op(0, PUSH, 3'd0, 4'hA, 1'b0, 4'h7, 3'd1, 1);
    op(0, PUSH, 3'd0, 4'hB, 1'b0, 4'h7, 3'd2, 1);
    op(0, PUSH, 3'd0, 4'hC, 1'b0, 4'h7, 3'd3, 1);
    op(0, GET, 3'd1, 4'h0, 1'b0, 4'hB, 3'd3, 1);
    op(0, GET, 3'd3, 4'h0, 1'b1, 4'hB, 3'd3, 1);
    op(0, GET, 3'd2, 4'h0, 1'b0, 4'hA, 3'd3, 1);
    op(1, NOP, 3'd0, 4'h0, 1'b0, 4'h1, 3'd3, 1);
    op(1, PUSH, 3'd0, 4'hD, 1'b0, 4'h1, 3'd4, 1);

    // Both requesters contend; last winner was 1 so the pointer now favours 0
    sb_push(0, 1'b0, 4'hD, 3'd3);
    sb_push(1, 1'b0, 4'hC, 3'd2);
    sb_push(0, 1'b0, 4'hB, 3'd1);
    sb_push(1, 1'b0, 4'hA, 3'd0);
    sb_push(0, 1'b1, 4'hB, 3'd0);
    fork
      begin
        op(0, POP, 3'd0, 4'h0, 1'b0, 4'h0, 3'd0, 0);
        op(0, POP, 3'd0, 4'h0, 1'b0, 4'h0, 3'd0, 0);
        op(0, POP, 3'd0, 4'h0, 1'b1, 4'h0, 3'd0, 0);
      end
      begin
        op(1, POP, 3'd0, 4'h0, 1'b0, 4'h0, 3'd0, 0);
        op(1, POP, 3'd0, 4'h0, 1'b0, 4'h0, 3'd0, 0);
      end
    join
    check("empty_after_contention", {7'd0, empty}, 8'd1);

    // Reset during the ISSUE cycle of a push
    set_req(0, 1'b1, PUSH, 3'd0, 4'h5);
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (gnt0) got = 1;
    end
    if (!got) timeout("abort_gnt_wait");
    check("abort_issue_command", {6'd0, stk_command}, {6'd0, PUSH});
    check("abort_issue_bus", {4'd0, stk_io}, 8'h05);
    set_req(0, 1'b0, NOP, 3'd0, 4'h0);
    rst_n = 1'b0;
    #1;
    check("abort_command", {6'd0, stk_command}, 8'd0);
    check("abort_stk_reset", {7'd0, stk_reset}, 8'd1);
    check("abort_count", {5'd0, count}, 8'd0);
    repeat (2) @(negedge clk);
    check("abort_no_done", {7'd0, done0}, 8'd0);
    rst_n = 1'b1;
    #1 check("abort_init_stk_reset", {7'd0, stk_reset}, 8'd1);
    @(negedge clk);
    check("abort_init_done", {7'd0, stk_reset}, 8'd0);
    op(1, PUSH, 3'd0, 4'h6, 1'b0, 4'h0, 3'd1, 1);
    check("post_abort_rdata0", {4'd0, rdata0}, 8'd0);

    repeat (4) @(negedge clk);
    check("scoreboard_drained", 8'(sbq.size()), 8'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
